// File: rtl/pipe_mem_access_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encodings, reset/write polarities
// and the ack-timeout limit and substitute read data.
package pipe_mem_access_pkg;

    localparam logic RST_ENABLED   = 1'b1;
    localparam logic WRITE_ENABLED = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam int          TIMEOUT_CNT_W = 8;
    localparam logic [7:0]  TIMEOUT_LIMIT = 8'd255;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

    // Upstream must freeze while an access is being launched or is outstanding.
    function automatic logic stall_needed(input mem_state_e st, input logic dmem_ena);
        return ((st == ST_IDLE) && dmem_ena) || (st == ST_BUSY);
    endfunction

endpackage

// File: rtl/pipe_mem_wb_reg.sv
// MEM/WB pipeline register: loads when enabled, turns into a bubble (no register
// write) while the stage is stalled and otherwise holds its contents.
module pipe_mem_wb_reg
    import pipe_mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wena,
    input  logic        bubble,
    input  logic [31:0] alu_out,
    input  logic [31:0] pc4,
    input  logic [31:0] dmem_rdata,
    input  logic [4:0]  rf_waddr,
    input  logic        rf_wena,
    input  logic [2:0]  rf_mux_sel,
    output logic [31:0] wb_alu_out,
    output logic [31:0] wb_pc4,
    output logic [31:0] wb_dmem_rdata,
    output logic [4:0]  wb_rf_waddr,
    output logic        wb_rf_wena,
    output logic [2:0]  wb_rf_mux_sel
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLED) begin
            wb_alu_out    <= 32'd0;
            wb_pc4        <= 32'd0;
            wb_dmem_rdata <= 32'd0;
            wb_rf_waddr   <= 5'd0;
            wb_rf_wena    <= 1'b0;
            wb_rf_mux_sel <= 3'd0;
        end else if (bubble) begin
            // Only the write enable is killed; the data fields keep their last values.
            wb_rf_wena    <= 1'b0;
        end else if (wena) begin
            wb_alu_out    <= alu_out;
            wb_pc4        <= pc4;
            wb_dmem_rdata <= dmem_rdata;
            wb_rf_waddr   <= rf_waddr;
            wb_rf_wena    <= rf_wena;
            wb_rf_mux_sel <= rf_mux_sel;
        end
    end

endmodule

// File: rtl/pipe_mem_access.sv
// MEM pipeline stage: drives a handshaked data-memory port and stalls the pipe until ack.
// Optional MEM_ACK_TIMEOUT_EN aborts an access after 255 unacked BUSY cycles and pulses err.
module pipe_mem_access
    import pipe_mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_alu_out,
    input  logic [31:0] mem_rt_data_out,
    input  logic [31:0] mem_pc4,
    input  logic        mem_dmem_ena,
    input  logic        mem_dmem_wena,
    input  logic [4:0]  mem_rf_waddr,
    input  logic        mem_rf_wena,
    input  logic [2:0]  mem_rf_mux_sel,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic [31:0] wb_alu_out,
    output logic [31:0] wb_pc4,
    output logic [31:0] wb_dmem_rdata,
    output logic [4:0]  wb_rf_waddr,
    output logic        wb_rf_wena,
    output logic [2:0]  wb_rf_mux_sel,
    output logic        err
);

    mem_state_e  state_reg;
    logic [31:0] rdata_reg;

    assign stall = stall_needed(state_reg, mem_dmem_ena);

`ifdef MEM_ACK_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0] timeout_cnt_reg;
    logic                     err_reg;

    assign err = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLED) begin
            state_reg       <= ST_IDLE;
            dm_req          <= 1'b0;
            dm_we           <= 1'b0;
            dm_addr         <= 32'd0;
            dm_wdata        <= 32'd0;
            rdata_reg       <= 32'd0;
            timeout_cnt_reg <= '0;
            err_reg         <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (mem_dmem_ena) begin
                        state_reg       <= ST_BUSY;
                        dm_req          <= 1'b1;
                        dm_we           <= mem_dmem_wena;
                        dm_addr         <= mem_alu_out;
                        dm_wdata        <= mem_rt_data_out;
                        timeout_cnt_reg <= '0;
                    end
                end
                ST_BUSY: begin
                    if (dm_ack) begin
                        state_reg <= ST_DONE;
                        dm_req    <= 1'b0;
                        rdata_reg <= (dm_we == WRITE_ENABLED) ? 32'd0 : dm_rdata;
                    end else if (timeout_cnt_reg == TIMEOUT_LIMIT - 8'd1) begin
                        // This cycle brings the count to the limit: give up on the access.
                        state_reg       <= ST_DONE;
                        dm_req          <= 1'b0;
                        rdata_reg       <= TIMEOUT_RDATA;
                        err_reg         <= 1'b1;
                        timeout_cnt_reg <= TIMEOUT_LIMIT;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    dm_req    <= 1'b0;
                end
            endcase
        end
    end
`else
    assign err = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLED) begin
            state_reg <= ST_IDLE;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= 32'd0;
            dm_wdata  <= 32'd0;
            rdata_reg <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mem_dmem_ena) begin
                        state_reg <= ST_BUSY;
                        dm_req    <= 1'b1;
                        dm_we     <= mem_dmem_wena;
                        dm_addr   <= mem_alu_out;
                        dm_wdata  <= mem_rt_data_out;
                    end
                end
                ST_BUSY: begin
                    if (dm_ack) begin
                        state_reg <= ST_DONE;
                        dm_req    <= 1'b0;
                        rdata_reg <= (dm_we == WRITE_ENABLED) ? 32'd0 : dm_rdata;
                    end
                end
                ST_DONE: begin
                    // mem_dmem_ena is still high for the finished access; do not reissue it.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    dm_req    <= 1'b0;
                end
            endcase
        end
    end
`endif

    pipe_mem_wb_reg u_wb_reg (
        .clk           (clk),
        .rst           (rst),
        .wena          (~stall),
        .bubble        (stall),
        .alu_out       (mem_alu_out),
        .pc4           (mem_pc4),
        .dmem_rdata    (rdata_reg),
        .rf_waddr      (mem_rf_waddr),
        .rf_wena       (mem_rf_wena),
        .rf_mux_sel    (mem_rf_mux_sel),
        .wb_alu_out    (wb_alu_out),
        .wb_pc4        (wb_pc4),
        .wb_dmem_rdata (wb_dmem_rdata),
        .wb_rf_waddr   (wb_rf_waddr),
        .wb_rf_wena    (wb_rf_wena),
        .wb_rf_mux_sel (wb_rf_mux_sel)
    );

endmodule

// File: tb/tb_pipe_mem_access.sv
// Directed bench for pipe_mem_access: ALU pass-through, load, slow store, back-to-back
// loads, async reset mid-access, and (with MEM_ACK_TIMEOUT_EN) the ack timeout.
module tb_pipe_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_alu_out, mem_rt_data_out, mem_pc4;
    logic        mem_dmem_ena, mem_dmem_wena;
    logic [4:0]  mem_rf_waddr;
    logic        mem_rf_wena;
    logic [2:0]  mem_rf_mux_sel;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall;
    logic [31:0] wb_alu_out, wb_pc4, wb_dmem_rdata;
    logic [4:0]  wb_rf_waddr;
    logic        wb_rf_wena;
    logic [2:0]  wb_rf_mux_sel;
    logic        err;

    int n_checks = 0;
    int n_fails  = 0;
    int stall_cycles, req_cycles, req_rises;
    logic req_prev;

    pipe_mem_access dut (
        .clk             (clk),
        .rst             (rst),
        .mem_alu_out     (mem_alu_out),
        .mem_rt_data_out (mem_rt_data_out),
        .mem_pc4         (mem_pc4),
        .mem_dmem_ena    (mem_dmem_ena),
        .mem_dmem_wena   (mem_dmem_wena),
        .mem_rf_waddr    (mem_rf_waddr),
        .mem_rf_wena     (mem_rf_wena),
        .mem_rf_mux_sel  (mem_rf_mux_sel),
        .dm_req          (dm_req),
        .dm_we           (dm_we),
        .dm_addr         (dm_addr),
        .dm_wdata        (dm_wdata),
        .dm_ack          (dm_ack),
        .dm_rdata        (dm_rdata),
        .stall           (stall),
        .wb_alu_out      (wb_alu_out),
        .wb_pc4          (wb_pc4),
        .wb_dmem_rdata   (wb_dmem_rdata),
        .wb_rf_waddr     (wb_rf_waddr),
        .wb_rf_wena      (wb_rf_wena),
        .wb_rf_mux_sel   (wb_rf_mux_sel),
        .err             (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, obs);
        end
    endtask

    task automatic clear_counts();
        stall_cycles = 0;
        req_cycles   = 0;
        req_rises    = 0;
        req_prev     = dm_req;
    endtask

    // Account for the current cycle, then advance to 1 time unit after the next rising edge.
    task automatic tick();
        #1;
        stall_cycles += int'(stall);
        req_cycles   += int'(dm_req);
        if (dm_req && !req_prev) req_rises++;
        req_prev = dm_req;
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic ena, input logic we, input logic [31:0] alu,
                           input logic [31:0] wdata, input logic [31:0] pc4,
                           input logic [4:0] waddr, input logic rfw, input logic [2:0] sel);
        mem_dmem_ena    = ena;
        mem_dmem_wena   = we;
        mem_alu_out     = alu;
        mem_rt_data_out = wdata;
        mem_pc4         = pc4;
        mem_rf_waddr    = waddr;
        mem_rf_wena     = rfw;
        mem_rf_mux_sel  = sel;
    endtask

    initial begin
        rst      = 1'b1;
        dm_ack   = 1'b0;
        dm_rdata = 32'd0;
        set_mem(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 3'd0);
        clear_counts();
        tick();
        tick();
        check("rst_dm_req", {31'd0, dm_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_wb_alu_out", wb_alu_out, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        // ALU op straight through, with a stray ack that must be ignored.
        clear_counts();
        set_mem(1'b0, 1'b0, 32'h10, 32'h0, 32'h44, 5'd5, 1'b1, 3'd1);
        dm_ack   = 1'b1;
        dm_rdata = 32'hBAD0BAD0;
        tick();
        dm_ack = 1'b0;
        check("alu_wb_alu_out", wb_alu_out, 32'h10);
        check("alu_wb_rf_waddr", {27'd0, wb_rf_waddr}, 32'd5);
        check("alu_wb_rf_wena", {31'd0, wb_rf_wena}, 32'd1);
        check("alu_wb_pc4", wb_pc4, 32'h44);
        check("alu_wb_mux_sel", {29'd0, wb_rf_mux_sel}, 32'd1);
        check("alu_stray_ack_rdata", wb_dmem_rdata, 32'd0);
        check("alu_dm_req", {31'd0, dm_req}, 32'd0);
        check("alu_stall_cycles", stall_cycles, 32'd0);

        // Load at 0x100, acked on the first BUSY cycle.
        clear_counts();
        set_mem(1'b1, 1'b0, 32'h100, 32'h0, 32'h48, 5'd7, 1'b1, 3'd2);
        #1;
        check("ld_stall_idle", {31'd0, stall}, 32'd1);
        tick();
        check("ld_dm_req", {31'd0, dm_req}, 32'd1);
        check("ld_dm_addr", dm_addr, 32'h100);
        check("ld_dm_we", {31'd0, dm_we}, 32'd0);
        check("ld_bubble_wena", {31'd0, wb_rf_wena}, 32'd0);
        check("ld_hold_alu_out", wb_alu_out, 32'h10);
        dm_ack   = 1'b1;
        dm_rdata = 32'hCAFEF00D;
        tick();
        dm_ack = 1'b0;
        check("ld_done_req", {31'd0, dm_req}, 32'd0);
        check("ld_done_stall", {31'd0, stall}, 32'd0);
        tick();
        check("ld_no_reissue", {31'd0, dm_req}, 32'd0);
        set_mem(1'b0, 1'b0, 32'h0, 32'h0, 32'h4C, 5'd0, 1'b0, 3'd0);
        check("ld_wb_rdata", wb_dmem_rdata, 32'hCAFEF00D);
        check("ld_wb_rf_wena", {31'd0, wb_rf_wena}, 32'd1);
        check("ld_wb_rf_waddr", {27'd0, wb_rf_waddr}, 32'd7);
        check("ld_wb_alu_out", wb_alu_out, 32'h100);
        check("ld_req_cycles", req_cycles, 32'd1);
        check("ld_stall_cycles", stall_cycles, 32'd2);

        // Store at 0x200, acked on the 4th BUSY cycle.
        clear_counts();
        set_mem(1'b1, 1'b1, 32'h200, 32'h55AA55AA, 32'h50, 5'd9, 1'b0, 3'd0);
        tick();
        for (int b = 1; b <= 4; b++) begin
            check($sformatf("st_b%0d_req", b), {31'd0, dm_req}, 32'd1);
            check($sformatf("st_b%0d_we", b), {31'd0, dm_we}, 32'd1);
            check($sformatf("st_b%0d_addr", b), dm_addr, 32'h200);
            check($sformatf("st_b%0d_wdata", b), dm_wdata, 32'h55AA55AA);
            if (b == 4) begin
                dm_ack   = 1'b1;
                dm_rdata = 32'h12345678;
            end
            tick();
        end
        dm_ack = 1'b0;
        check("st_done_req", {31'd0, dm_req}, 32'd0);
        tick();
        check("st_no_reissue", {31'd0, dm_req}, 32'd0);
        set_mem(1'b0, 1'b0, 32'h0, 32'h0, 32'h54, 5'd0, 1'b0, 3'd0);
        check("st_wb_rdata", wb_dmem_rdata, 32'd0);
        check("st_wb_rf_wena", {31'd0, wb_rf_wena}, 32'd0);
        check("st_wb_alu_out", wb_alu_out, 32'h200);
        check("st_stall_cycles", stall_cycles, 32'd5);
        check("st_req_cycles", req_cycles, 32'd4);
        check("st_req_rises", req_rises, 32'd1);

        // Back-to-back loads, the second presented right after the first retires.
        clear_counts();
        set_mem(1'b1, 1'b0, 32'h400, 32'h0, 32'h60, 5'd3, 1'b1, 3'd2);
        tick();
        dm_ack   = 1'b1;
        dm_rdata = 32'h11112222;
        tick();
        dm_ack = 1'b0;
        check("b2b_a_bubble", {31'd0, wb_rf_wena}, 32'd0);
        tick();
        set_mem(1'b1, 1'b0, 32'h404, 32'h0, 32'h64, 5'd4, 1'b1, 3'd2);
        check("b2b_a_rdata", wb_dmem_rdata, 32'h11112222);
        check("b2b_a_waddr", {27'd0, wb_rf_waddr}, 32'd3);
        check("b2b_a_wena", {31'd0, wb_rf_wena}, 32'd1);
        tick();
        check("b2b_b_addr", dm_addr, 32'h404);
        check("b2b_b_bubble", {31'd0, wb_rf_wena}, 32'd0);
        check("b2b_b_hold_rdata", wb_dmem_rdata, 32'h11112222);
        dm_ack   = 1'b1;
        dm_rdata = 32'h33334444;
        tick();
        dm_ack = 1'b0;
        tick();
        set_mem(1'b0, 1'b0, 32'h0, 32'h0, 32'h68, 5'd0, 1'b0, 3'd0);
        check("b2b_b_rdata", wb_dmem_rdata, 32'h33334444);
        check("b2b_b_waddr", {27'd0, wb_rf_waddr}, 32'd4);
        check("b2b_b_wena", {31'd0, wb_rf_wena}, 32'd1);
        check("b2b_req_rises", req_rises, 32'd2);

        // Async reset in the 2nd BUSY cycle, then a spurious ack.
        set_mem(1'b1, 1'b0, 32'h300, 32'h0, 32'h70, 5'd6, 1'b1, 3'd1);
        tick();
        tick();
        check("rstb_busy_req", {31'd0, dm_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstb_dm_req", {31'd0, dm_req}, 32'd0);
        check("rstb_dm_addr", dm_addr, 32'd0);
        check("rstb_wb_alu_out", wb_alu_out, 32'd0);
        check("rstb_wb_pc4", wb_pc4, 32'd0);
        check("rstb_wb_rdata", wb_dmem_rdata, 32'd0);
        check("rstb_wb_waddr", {27'd0, wb_rf_waddr}, 32'd0);
        set_mem(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 3'd0);
        tick();
        rst      = 1'b0;
        dm_ack   = 1'b1;
        dm_rdata = 32'hFEEDFACE;
        clear_counts();
        tick();
        tick();
        dm_ack = 1'b0;
        check("rstb_ack_ignored_req", {31'd0, dm_req}, 32'd0);
        check("rstb_ack_ignored_rdata", wb_dmem_rdata, 32'd0);
        check("rstb_ack_ignored_stall", stall_cycles, 32'd0);

`ifdef MEM_ACK_TIMEOUT_EN
        begin
            int busy_ticks;
            bit seen;
            busy_ticks = 0;
            seen = 1'b0;
            set_mem(1'b1, 1'b0, 32'h500, 32'h0, 32'h80, 5'd8, 1'b1, 3'd2);
            tick();
            for (int i = 0; i < 300 && !seen; i++) begin
                tick();
                busy_ticks++;
                if (err) seen = 1'b1;
            end
            check("to_err_seen", {31'd0, seen}, 32'd1);
            check("to_busy_cycles", busy_ticks, 32'd255);
            check("to_stall_released", {31'd0, stall}, 32'd0);
            tick();
            set_mem(1'b0, 1'b0, 32'h0, 32'h0, 32'h84, 5'd0, 1'b0, 3'd0);
            check("to_err_pulse", {31'd0, err}, 32'd0);
            check("to_wb_rdata", wb_dmem_rdata, 32'hDEADBEEF);
            check("to_dm_req", {31'd0, dm_req}, 32'd0);
        end
`else
        check("no_timeout_err", {31'd0, err}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
